// File: rtl/conv3x3_stream_engine.sv
// conv3x3_stream_engine
// Streaming 3x3 correlation engine. Pixels arrive in raster order. Two line
// buffers plus a 3x3 window register feed a single-cycle MAC. The engine emits
// one shifted and saturated result for every window position that lies fully
// inside the image, so there are (IMG_W-2)x(IMG_H-2) results per frame.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   start                begins a frame (IDLE only)
//   k_we/k_addr/k_data   kernel coefficient write (IDLE only, addr 0..8)
//   pix_valid/pix_ready/pix_data   input pixel stream
//   out_valid/out_ready/out_data/out_acc   result stream (saturated + raw)
//   busy                 state != IDLE
//   done                 one-cycle pulse at end of frame
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds its valid and data stable until that transfer occurs.
// pix_ready is low whenever a result is held and not being consumed, so no
// result is ever overwritten.
module conv3x3_stream_engine #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     k_we,
    input  logic [3:0]               k_addr,
    input  logic [COEF_W-1:0]        k_data,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [DATA_W-1:0]        pix_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic                     busy,
    output logic                     done
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}});

    logic [1:0]               state;
    logic signed [COEF_W-1:0] kernel   [9];
    logic [DATA_W-1:0]        linebuf0 [IMG_W];
    logic [DATA_W-1:0]        linebuf1 [IMG_W];
    logic [DATA_W-1:0]        win      [3][3];
    logic [DATA_W-1:0]        nwin     [3][3];
    logic [DATA_W-1:0]        new_col  [3];
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic                     last_taken;   // final pixel of the frame accepted
    logic                     pix_fire;
    logic                     win_ok;
    logic                     last_pix;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_shift;
    logic [DATA_W-1:0]        sat_next;

    // Unsigned pixel times signed coefficient, both widened to ACC_W.
    function automatic logic signed [ACC_W-1:0] mul_term(
        input logic [DATA_W-1:0]        p,
        input logic signed [COEF_W-1:0] k
    );
        return $signed({{(ACC_W-DATA_W){1'b0}}, p}) *
               $signed({{(ACC_W-COEF_W){k[COEF_W-1]}}, k});
    endfunction

    assign pix_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign pix_fire  = pix_valid && pix_ready;
    assign win_ok    = (row >= RW'(2)) && (col >= CW'(2));
    assign last_pix  = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // The window as it will look after the current pixel is shifted in; the
    // MAC works on this so the result registers on the accepting edge.
    always_comb begin
        new_col[0] = linebuf1[col];
        new_col[1] = linebuf0[col];
        new_col[2] = pix_data;
        acc_next   = '0;
        for (int i = 0; i < 3; i++) begin
            nwin[i][0] = win[i][1];
            nwin[i][1] = win[i][2];
            nwin[i][2] = new_col[i];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc_next = acc_next + mul_term(nwin[i][j], kernel[3*i+j]);
            end
        end
        acc_shift = acc_next >>> SHIFT;
        if (acc_shift < 0) begin
            sat_next = '0;
        end else if (acc_shift > SAT_MAX) begin
            sat_next = '1;
        end else begin
            sat_next = acc_shift[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_RUN;
                // last_taken rises together with the final result, so this
                // handshake is the final result leaving.
                ST_RUN:  if (last_taken && out_valid && out_ready) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) kernel[i] <= '0;
        end else if (state == ST_IDLE && k_we && k_addr < 4'd9) begin
            kernel[k_addr] <= $signed(k_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            last_taken <= 1'b0;
            for (int c = 0; c < IMG_W; c++) begin
                linebuf0[c] <= '0;
                linebuf1[c] <= '0;
            end
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) win[i][j] <= '0;
        end else if (state == ST_IDLE && start) begin
            row        <= '0;
            col        <= '0;
            last_taken <= 1'b0;
            for (int c = 0; c < IMG_W; c++) begin
                linebuf0[c] <= '0;
                linebuf1[c] <= '0;
            end
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) win[i][j] <= '0;
        end else if (pix_fire) begin
            linebuf1[col] <= linebuf0[col];
            linebuf0[col] <= pix_data;
            win           <= nwin;
            if (last_pix) last_taken <= 1'b1;
            if (col == CW'(IMG_W-1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H-1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // A new result has priority over retiring the held one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_data  <= '0;
        end else if (pix_fire && win_ok) begin
            out_valid <= 1'b1;
            out_acc   <= acc_next;
            out_data  <= sat_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
